// File: rtl/l0_cache_inval_ctrl_if.sv
// rtl/l0_cache_inval_ctrl_if.sv - request/clear/status bundle between pipeline side and the L0 invalidation sequencer
interface l0_cache_inval_ctrl_if #(
    parameter int CACHE_DEPTH = 128
) ();
    localparam int IW = $clog2(CACHE_DEPTH);

    logic          i_flush_req;
    logic          i_inval_valid;
    logic [IW-1:0] i_inval_index;
    logic          o_inval_ready;
    logic          i_cache_write_active;
    logic          o_clear_we;
    logic [IW-1:0] o_clear_index;
    logic          o_busy;
    logic          o_stall_req;
    logic          o_flush_done;

    modport master (
        output i_flush_req, i_inval_valid, i_inval_index, i_cache_write_active,
        input  o_inval_ready, o_clear_we, o_clear_index, o_busy, o_stall_req, o_flush_done
    );

    modport slave (
        input  i_flush_req, i_inval_valid, i_inval_index, i_cache_write_active,
        output o_inval_ready, o_clear_we, o_clear_index, o_busy, o_stall_req, o_flush_done
    );
endinterface

// File: rtl/l0_cache_inval_ctrl.sv
// rtl/l0_cache_inval_ctrl.sv - L0 valid-bit clear sequencer: full sweeps plus queued single-line invalidations
module l0_cache_inval_ctrl #(
    parameter int CACHE_DEPTH  = 128,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    l0_cache_inval_ctrl_if.slave  bus
);
    localparam int IW = $clog2(CACHE_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] sweep_idx_q, sweep_idx_d;
    logic          pending_q, pending_d;
    logic          requested_q, requested_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          done_q, done_d;
    logic [FW:0]   wr_ptr_q, rd_ptr_q;
    logic [IW-1:0] fifo_mem [FIFO_DEPTH];

    logic          fifo_empty, fifo_full, push, pop, sweep_entry;
    logic          clear_we;
    logic [IW-1:0] clear_index;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FW] != rd_ptr_q[FW]) && (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);
    assign push       = bus.i_inval_valid && !fifo_full && !i_rst;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        pending_d   = pending_q;
        requested_d = requested_q;
        starve_d    = starve_q;
        stall_d     = 1'b0;
        done_d      = 1'b0;
        pop         = 1'b0;
        sweep_entry = 1'b0;
        clear_we    = 1'b0;
        clear_index = fifo_mem[rd_ptr_q[FW-1:0]];

        case (state_q)
            ST_SWEEP: begin
                clear_we    = 1'b1;
                clear_index = sweep_idx_q;
                if (bus.i_flush_req) pending_d = 1'b1;
                if (&sweep_idx_q) begin
                    done_d = requested_q;
                    // A request collected during this sweep restarts immediately instead of idling.
                    if (pending_q || bus.i_flush_req) begin
                        sweep_entry = 1'b1;
                        requested_d = 1'b1;
                        pending_d   = 1'b0;
                        sweep_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            default: begin
                if (!fifo_empty) begin
                    if (!bus.i_cache_write_active) begin
                        pop      = 1'b1;
                        clear_we = 1'b1;
                        starve_d = '0;
                    end else if (starve_q != SW'(STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                        stall_d  = (starve_q == SW'(STARVE_LIMIT - 1));
                    end
                end
                if (bus.i_flush_req) begin
                    sweep_entry = 1'b1;
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                    requested_d = 1'b1;
                end
            end
        endcase

        if (sweep_entry) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end
        if (i_rst) begin
            clear_we    = 1'b0;
            clear_index = '0;
            pop         = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
            pending_q   <= 1'b0;
            requested_q <= 1'b0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            pending_q   <= pending_d;
            requested_q <= requested_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            // Sweep entry drops only what was queued before this cycle; a same-cycle push survives.
            if (sweep_entry)  rd_ptr_q <= wr_ptr_q;
            else if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q[FW-1:0]] <= bus.i_inval_index;
    end

    assign bus.o_inval_ready = !fifo_full && !i_rst;
    assign bus.o_clear_we    = clear_we;
    assign bus.o_clear_index = clear_index;
    assign bus.o_busy        = i_rst || (state_q == ST_SWEEP);
    assign bus.o_stall_req   = stall_q;
    assign bus.o_flush_done  = done_q;
endmodule

// File: tb/tb_l0_cache_inval_ctrl.sv
// tb/tb_l0_cache_inval_ctrl.sv - self-checking bench for l0_cache_inval_ctrl
module tb_l0_cache_inval_ctrl;
    localparam int CD = 128;
    localparam int FD = 4;
    localparam int SL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l0_cache_inval_ctrl_if #(.CACHE_DEPTH(CD)) bus ();

    l0_cache_inval_ctrl #(.CACHE_DEPTH(CD), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: queue of pending line indices, sweep position (-1 when idle), scheduled pulses.
    int q[$];
    int sweep_pos  = 0;
    bit pend       = 1'b0;
    bit reqd       = 1'b0;
    int defer      = 0;
    bit exp_stall  = 1'b0;
    bit exp_done   = 1'b0;
    bit prev_stall = 1'b0;
    int clears     = 0;
    int dones      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit flush, input bit valid, input int idx, input bit wa);
        bus.i_flush_req          = flush;
        bus.i_inval_valid        = valid;
        bus.i_inval_index        = 7'(idx);
        bus.i_cache_write_active = prev_stall ? 1'b0 : wa;
    endtask

    task automatic cycle();
        bit we_e, acc, nstall, ndone, wa, fl;
        @(negedge clk);
        wa = bus.i_cache_write_active;
        fl = bus.i_flush_req;
        if (rst) begin
            chk("rst_clear_we", 32'(bus.o_clear_we), 0);
            chk("rst_clear_index", 32'(bus.o_clear_index), 0);
            chk("rst_busy", 32'(bus.o_busy), 1);
            chk("rst_ready", 32'(bus.o_inval_ready), 0);
        end else begin
            we_e = (sweep_pos >= 0) || (q.size() > 0 && !wa);
            chk("clear_we", 32'(bus.o_clear_we), 32'(we_e));
            if (we_e) chk("clear_index", 32'(bus.o_clear_index), (sweep_pos >= 0) ? sweep_pos : q[0]);
            chk("busy", 32'(bus.o_busy), 32'(sweep_pos >= 0));
            chk("inval_ready", 32'(bus.o_inval_ready), 32'(q.size() < FD));
        end
        chk("stall_req", 32'(bus.o_stall_req), 32'(exp_stall));
        chk("flush_done", 32'(bus.o_flush_done), 32'(exp_done));
        if (bus.o_clear_we)   clears++;
        if (bus.o_flush_done) dones++;

        prev_stall = exp_stall;
        if (rst) begin
            q.delete();
            sweep_pos = 0; pend = 0; reqd = 0; defer = 0;
            exp_stall = 0; exp_done = 0; prev_stall = 0;
        end else begin
            acc    = bus.i_inval_valid && (q.size() < FD);
            nstall = 0;
            ndone  = 0;
            if (sweep_pos >= 0) begin
                if (fl) pend = 1;
                if (sweep_pos == CD - 1) begin
                    ndone = reqd;
                    if (pend) begin
                        q.delete(); reqd = 1; pend = 0; sweep_pos = 0; defer = 0;
                    end else begin
                        sweep_pos = -1;
                    end
                end else begin
                    sweep_pos++;
                end
            end else begin
                if (q.size() > 0 && !wa) begin
                    void'(q.pop_front());
                    defer = 0;
                end else if (q.size() > 0 && defer < SL) begin
                    defer++;
                    nstall = (defer == SL);
                end
                if (fl) begin
                    q.delete(); sweep_pos = 0; reqd = 1; defer = 0; nstall = 0;
                end
            end
            if (acc) q.push_back(int'(bus.i_inval_index));
            exp_stall = nstall;
            exp_done  = ndone;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();

        // Reset sweep
        rst = 1'b0;
        clears = 0; dones = 0;
        for (int i = 0; i < 130; i++) begin
            drive(0, 0, 0, ($urandom_range(0, 1) == 1));
            cycle();
        end
        chk("reset_sweep_clears", clears, 128);
        chk("reset_sweep_done", dones, 0);

        // Flush from idle after ten idle cycles
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle();
        clears = 0; dones = 0;
        drive(1, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 130; i++) cycle();
        chk("flush_sweep_clears", clears, 128);
        chk("flush_sweep_done", dones, 1);

        // Two requests during one sweep collapse into one follow-on
        clears = 0; dones = 0;
        drive(1, 0, 0, 0); cycle();
        drive(0, 0, 0, 0); for (int i = 0; i < 5; i++) cycle();
        drive(1, 0, 0, 0); cycle();
        drive(0, 0, 0, 0); for (int i = 0; i < 20; i++) cycle();
        drive(1, 0, 0, 0); cycle();
        drive(0, 0, 0, 0); for (int i = 0; i < 240; i++) cycle();
        chk("double_flush_clears", clears, 256);
        chk("double_flush_done", dones, 2);

        // Back-to-back line invalidations without contention
        clears = 0;
        drive(0, 1, 5, 0); cycle();
        drive(0, 1, 9, 0); cycle();
        drive(0, 1, 5, 0); cycle();
        drive(0, 0, 0, 0); for (int i = 0; i < 3; i++) cycle();
        chk("line_clears", clears, 3);

        // Fill under contention, starve, forced slot
        for (int i = 0; i < FD; i++) begin
            drive(0, 1, 20 + i, 1);
            cycle();
        end
        chk("full_ready", 32'(bus.o_inval_ready), 0);
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 1);
            cycle();
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle();

        // Queued line covered by a sweep; line enqueued during the sweep survives
        drive(0, 1, 3, 1); cycle();
        drive(1, 0, 0, 1); cycle();
        drive(0, 1, 7, 0); cycle();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 130; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, CD - 1)), ($urandom_range(0, 9) < 7));
            cycle();
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 140; i++) cycle();

        // Reset in the middle of activity
        rst = 1'b1;
        drive(0, 1, 11, 0);
        for (int i = 0; i < 2; i++) cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 132; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
